// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, BCD digit width, start/terminal digit helpers.
package stopwatch_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_END   = 2'd3
  } swState_e;

  // Counting up stops at all nines, counting down stops at all zeros.
  function automatic logic [BCD_W-1:0] termDigit(input logic down);
    return down ? 4'd0 : 4'd9;
  endfunction

  function automatic logic [BCD_W-1:0] startDigit(input logic [1:0] modeSel,
                                                  input logic [BCD_W-1:0] presetDigit);
    if (modeSel[0]) return (presetDigit > 4'd9) ? 4'd9 : presetDigit;
    return modeSel[1] ? 4'd9 : 4'd0;
  endfunction
endpackage

// File: rtl/stopwatch_bcd_step.sv
// Combinational N-digit BCD +1/-1 with full ripple carry/borrow; wraps at 99..9 / 00..0.
module bcd_step
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic [BCD_W*N_DIGITS-1:0] value,
  input  logic                      down,
  output logic [BCD_W*N_DIGITS-1:0] result
);
  logic             carry;
  logic [BCD_W-1:0] digit;
  logic [BCD_W-1:0] nextDigit;

  always_comb begin
    result    = '0;
    carry     = 1'b1;
    digit     = '0;
    nextDigit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit = value[i*BCD_W +: BCD_W];
      if (!carry) begin
        nextDigit = digit;
      end else if (down) begin
        if (digit == 4'd0) begin
          nextDigit = 4'd9;
        end else begin
          nextDigit = digit - 4'd1;
          carry     = 1'b0;
        end
      end else begin
        if (digit >= 4'd9) begin
          nextDigit = 4'd0;
        end else begin
          nextDigit = digit + 4'd1;
          carry     = 1'b0;
        end
      end
      result[i*BCD_W +: BCD_W] = nextDigit;
    end
  end
endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch: prescaled run/pause/end FSM with preset/internal start and terminal done pulse.
// Optional lap capture register enabled by STOPWATCH_LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      start_stop,
  input  logic                      clear,
  input  logic                      lap,
  input  logic [1:0]                mode,
  input  logic [BCD_W*N_DIGITS-1:0] preset_val,
  output logic [BCD_W*N_DIGITS-1:0] bcd_out,
  output logic [1:0]                state,
  output logic                      done,
  output logic [BCD_W*N_DIGITS-1:0] lap_out,
  output logic                      lap_valid
);
  localparam int W = BCD_W * N_DIGITS;
  localparam logic [9:0] PRE_LAST = 10'(TICK_DIV - 1);

  swState_e     stateQ;
  logic [9:0]   prescaler;
  logic [W-1:0] startValue;
  logic [W-1:0] termValue;
  logic [W-1:0] stepValue;

  for (genvar d = 0; d < N_DIGITS; d++) begin : gDigit
    assign termValue[d*BCD_W +: BCD_W]  = termDigit(mode[1]);
    assign startValue[d*BCD_W +: BCD_W] = startDigit(mode, preset_val[d*BCD_W +: BCD_W]);
  end

  bcd_step #(.N_DIGITS(N_DIGITS)) uStep (
    .value  (bcd_out),
    .down   (mode[1]),
    .result (stepValue)
  );

  assign state = stateQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= ST_IDLE;
      bcd_out   <= '0;
      prescaler <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        stateQ    <= ST_IDLE;
        bcd_out   <= startValue;
        prescaler <= '0;
      end else begin
        // A start_stop-driven transition swallows any tick in the same cycle.
        case (stateQ)
          ST_IDLE: begin
            if (start_stop) begin
              if (bcd_out == termValue) begin
                stateQ <= ST_END;
                done   <= 1'b1;
              end else begin
                stateQ <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (start_stop) begin
              stateQ <= ST_PAUSE;
            end else if (tick) begin
              if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                bcd_out   <= stepValue;
                if (stepValue == termValue) begin
                  stateQ <= ST_END;
                  done   <= 1'b1;
                end
              end else begin
                prescaler <= prescaler + 10'd1;
              end
            end
          end
          ST_PAUSE: begin
            if (start_stop) stateQ <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_out   <= '0;
      lap_valid <= 1'b0;
    end else if (lap && (stateQ == ST_RUN || stateQ == ST_PAUSE)) begin
      lap_out   <= bcd_out;
      lap_valid <= 1'b1;
    end
  end
`else
  logic unusedLap;
  assign unusedLap = lap;
  assign lap_out   = '0;
  assign lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with N_DIGITS=4, TICK_DIV=4; lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] preset_val = 16'h0000;
  logic [15:0] bcd_out;
  logic [1:0]  state;
  logic        done;
  logic [15:0] lap_out;
  logic        lap_valid;

  int errors = 0;
  int checks = 0;
  int doneSeen = 0;

  stopwatch_core #(.N_DIGITS(4), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .mode       (mode),
    .preset_val (preset_val),
    .bcd_out    (bcd_out),
    .state      (state),
    .done       (done),
    .lap_out    (lap_out),
    .lap_valid  (lap_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseSS();
    start_stop = 1'b1; step(); start_stop = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (done) doneSeen++;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; start_stop = 1'b1; clear = 1'b1; lap = 1'b1;
    step(); step();
    reset = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    check("rst_bcd", bcd_out, 0);
    check("rst_state", state, 0);
    check("rst_done", done, 0);
    check("rst_lap_out", lap_out, 0);
    check("rst_lap_valid", lap_valid, 0);

    // Basic up count
    mode = 2'b00; pulseClear();
    check("clr_bcd", bcd_out, 16'h0000);
    check("clr_state", state, 0);
    pulseSS();
    check("run_state", state, 1);
    ticks(8);
    check("up8_bcd", bcd_out, 16'h0002);
    check("up8_state", state, 1);
    ticks(3);
    check("presc3_bcd", bcd_out, 16'h0002);
    ticks(1);
    check("presc_wrap_bcd", bcd_out, 16'h0003);

    // Pause holds prescaler and count
    pulseClear(); pulseSS(); ticks(2); pulseSS();
    check("pause_state", state, 2);
    ticks(10);
    check("pause_bcd", bcd_out, 16'h0000);
    pulseSS();
    check("resume_state", state, 1);
    ticks(2);
    check("pause_one_step", bcd_out, 16'h0001);
    start_stop = 1'b1; tick = 1'b1; step(); start_stop = 1'b0; tick = 1'b0;
    check("ss_tick_state", state, 2);
    pulseSS(); ticks(3);
    check("ss_tick_ignored", bcd_out, 16'h0001);
    ticks(1);
    check("ss_tick_step", bcd_out, 16'h0002);

    // Carry and terminal count up
    mode = 2'b01; preset_val = 16'h0999; pulseClear();
    check("preset_bcd", bcd_out, 16'h0999);
    pulseSS(); ticks(4);
    check("carry_bcd", bcd_out, 16'h1000);
    preset_val = 16'h9998; pulseClear(); pulseSS();
    doneSeen = 0; ticks(8);
    check("term_up_bcd", bcd_out, 16'h9999);
    check("term_up_done", doneSeen, 1);
    check("term_up_state", state, 3);
    doneSeen = 0; ticks(4); pulseSS(); ticks(4);
    check("end_hold_bcd", bcd_out, 16'h9999);
    check("end_hold_state", state, 3);
    check("end_no_done", doneSeen, 0);

    // Down count, borrow, clamp, internal nines
    mode = 2'b11; preset_val = 16'h0001; pulseClear(); pulseSS();
    doneSeen = 0; ticks(4);
    check("term_dn_bcd", bcd_out, 16'h0000);
    check("term_dn_done", doneSeen, 1);
    check("term_dn_state", state, 3);
    preset_val = 16'h1000; pulseClear(); pulseSS(); ticks(4);
    check("borrow_bcd", bcd_out, 16'h0999);
    check("borrow_state", state, 1);
    preset_val = 16'h00A5; pulseClear();
    check("clamp_bcd", bcd_out, 16'h0095);
    mode = 2'b10; pulseClear();
    check("nines_bcd", bcd_out, 16'h9999);
    mode = 2'b11; preset_val = 16'h0000; pulseClear(); pulseSS();
    check("idle_term_done", done, 1);
    check("idle_term_state", state, 3);
    step();
    check("idle_term_done_drop", done, 0);
    check("idle_term_no_step", bcd_out, 16'h0000);

    // Clear beats start_stop in RUN
    mode = 2'b01; preset_val = 16'h0012; pulseClear(); pulseSS(); ticks(4);
    check("pre_clr_bcd", bcd_out, 16'h0013);
    clear = 1'b1; start_stop = 1'b1; step(); clear = 1'b0; start_stop = 1'b0;
    check("clr_ss_state", state, 0);
    check("clr_ss_bcd", bcd_out, 16'h0012);

    // Lap capture
    pulseSS();
    lap = 1'b1; step(); lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    check("lap_out", lap_out, 16'h0012);
    check("lap_valid", lap_valid, 1);
`else
    check("lap_off_out", lap_out, 0);
    check("lap_off_valid", lap_valid, 0);
`endif
    ticks(4);
    check("lap_count_on", bcd_out, 16'h0013);
`ifdef STOPWATCH_LAP_EN
    check("lap_hold", lap_out, 16'h0012);
    pulseClear();
    check("lap_clr_valid", lap_valid, 0);
    check("lap_clr_out", lap_out, 0);
`else
    check("lap_off_valid2", lap_valid, 0);
    pulseClear();
`endif

    // Reset mid-run
    pulseSS(); ticks(2);
    reset = 1'b1; tick = 1'b1; step(); reset = 1'b0; tick = 1'b0;
    check("mid_rst_bcd", bcd_out, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_lap_out", lap_out, 0);
    check("mid_rst_lap_valid", lap_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of BCD digits (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 100, number of tick pulses per count step (1..1023).
REQ-003 SHALL have input clk, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have input reset, 1 bit, synchronous active-high reset.
REQ-005 SHALL have input tick, 1 bit, one-cycle base-rate enable.
REQ-006 SHALL have input start_stop, 1 bit, one-cycle pulse that toggles run/pause.
REQ-007 SHALL have input clear, 1 bit, one-cycle pulse that reloads the start value.
REQ-008 SHALL have input lap, 1 bit, one-cycle lap-capture pulse.
REQ-009 SHALL have input mode, 2 bits: [1] is the direction (0 up, 1 down); [0] is the start source (0 internal, 1 preset).
REQ-010 SHALL have input preset_val, 4*N_DIGITS bits, external BCD start value.
REQ-011 SHALL have output bcd_out, 4*N_DIGITS bits, current count.
REQ-012 SHALL have output state, 2 bits, FSM state encoding.
REQ-013 SHALL have output done, 1 bit, one-cycle pulse when the terminal count is reached.
REQ-014 SHALL have output lap_out, 4*N_DIGITS bits, captured lap value.
REQ-015 SHALL have output lap_valid, 1 bit, set when lap_out holds a capture.

Function
REQ-016 SHALL implement the states IDLE=0, RUN=1, PAUSE=2 and END=3.
REQ-017 SHALL define the start value as follows:
- mode[0]=1: preset_val, with any digit >9 clamped to 9.
- mode[0]=0, mode[1]=0: all zeros.
- mode[0]=0, mode[1]=1: all nines.
REQ-018 SHALL define the terminal value as all nines when counting up and all zeros when counting down.
REQ-019 SHALL, on clear in any state, load the start value into bcd_out, zero the prescaler and enter IDLE the next cycle.
REQ-020 SHALL give clear priority over start_stop, lap and tick in the same cycle.
REQ-021 SHALL make the IDLE transition on start_stop as follows:
- To RUN, normally.
- To END with a done pulse and no step, if bcd_out already equals the terminal value.
REQ-022 SHALL move RUN to PAUSE and PAUSE to RUN on start_stop.
REQ-023 SHALL keep the prescaler and bcd_out unchanged while in PAUSE.
REQ-024 SHALL ignore start_stop and tick while in END; only clear or reset leaves END.
REQ-025 SHALL advance the prescaler 0..TICK_DIV-1 on each tick while in RUN; the wrap from TICK_DIV-1 to 0 is a step.
REQ-026 SHALL update bcd_out on the cycle after a step, by +1 or -1 in BCD with full digit carry/borrow.
REQ-027 SHALL, for a step that produces the terminal value, enter END and assert done for exactly one cycle, both in the same cycle bcd_out takes that value.
REQ-028 SHALL sample mode[1] continuously.
REQ-029 SHALL apply mode[0] only at clear.
REQ-030 SHALL ignore tick in the same cycle as a start_stop-driven state change.

Reset
REQ-031 SHALL, on reset, set state=IDLE, bcd_out=0, prescaler=0, done=0, lap_out=0 and lap_valid=0.
REQ-032 SHALL give reset priority over all other inputs.

Configuration
REQ-033 SHALL use the macro STOPWATCH_LAP_EN, with the following behaviour:
- Defined: lap in RUN or PAUSE copies bcd_out into lap_out and sets lap_valid the next cycle; clear zeroes both.
- Undefined: the lap input is ignored, and lap_out and lap_valid are tied to 0.
- The ports exist in both builds.

Structure
REQ-034 SHALL place the state encoding, the BCD digit width constant (4) and the terminal/start value functions in the shared package stopwatch_pkg.
REQ-035 SHALL implement the N-digit BCD increment/decrement as the combinational sub-module bcd_step, parametrised by N_DIGITS.

Verification
REQ-036 SHALL check, with N=4, TICK_DIV=4 and mode=00: clear, start_stop, 8 ticks -> bcd_out=0x0002, state=RUN.
REQ-037 SHALL check carry: preset 0x0999, mode=01, clear, run, 4 ticks -> bcd_out=0x1000; from 0x9998, 8 ticks -> bcd_out=0x9999, done pulse, state=END; further ticks have no effect.
REQ-038 SHALL check down-counting: mode=11, preset 0x0001, clear, run, 4 ticks -> bcd_out=0x0000, done, END; preset 0x00A5 -> start value 0x0095.
REQ-039 SHALL check pause: run, 2 ticks, start_stop, 10 ticks, start_stop, 2 ticks -> exactly one step taken.
REQ-040 SHALL check the simultaneous event and reset mid-run: clear+start_stop in RUN -> IDLE with the start value; reset mid-RUN -> all outputs 0, IDLE.
REQ-041 SHALL check lap with STOPWATCH_LAP_EN: lap at 0x0012 -> lap_out=0x0012, lap_valid=1, counting continues; without the macro -> lap_valid stays 0.
